// File: rtl/lsu_ctrl_rv32i_if.sv
// Core-request, response and data-memory port bundle for the RV32I load/store controller.
// The master modport is the controller's view; slave is the core/memory side.
interface lsu_ctrl_rv32i_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        dmem_req;
    logic        dmem_gnt;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        dmem_err;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
    );
endinterface

// File: rtl/lsu_ctrl_rv32i.sv
// RV32I load/store controller: validates one request, runs a req/gnt/rvalid word access with
// a response timeout, and returns lane-extracted, extended load data or an error.
module lsu_ctrl_rv32i #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    lsu_ctrl_rv32i_if.master lsu_io
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               req_illegal;
    logic               timeout;
    logic [7:0]         byte_lane;
    logic [15:0]        half_lane;
    logic [31:0]        load_data;

    // Legality is judged on the live request so an illegal one skips the bus entirely.
    always_comb begin
        req_illegal = 1'b0;
        if (lsu_io.req_we) begin
            req_illegal = lsu_io.req_funct3[2] | (lsu_io.req_funct3[1:0] == 2'b11);
        end else begin
            req_illegal = (lsu_io.req_funct3[1:0] == 2'b11) |
                          (lsu_io.req_funct3[2] & lsu_io.req_funct3[1]);
        end
        case (lsu_io.req_funct3[1:0])
            2'b01:   if (lsu_io.req_addr[0]) req_illegal = 1'b1;
            2'b10:   if (lsu_io.req_addr[1:0] != 2'b00) req_illegal = 1'b1;
            default: ;
        endcase
    end

    assign timeout = (cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);

    always_comb begin
        byte_lane = lsu_io.dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_lane = lsu_io.dmem_rdata[{addr_q[1], 4'b0000} +: 16];
        load_data = lsu_io.dmem_rdata;
        case (funct3_q)
            3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_data = {24'b0, byte_lane};
            3'b101:  load_data = {16'b0, half_lane};
            default: load_data = lsu_io.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (lsu_io.req_valid) state_d = req_illegal ? StResp : StIssue;
            StIssue: if (lsu_io.dmem_gnt) state_d = StWait;
            StWait:  if (lsu_io.dmem_rvalid || timeout) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (lsu_io.req_valid) begin
                    we_d     = lsu_io.req_we;
                    funct3_d = lsu_io.req_funct3;
                    addr_d   = lsu_io.req_addr;
                    wdata_d  = lsu_io.req_wdata;
                    err_d    = req_illegal;
                    rdata_d  = '0;
                end
            end
            StIssue: if (lsu_io.dmem_gnt) cnt_d = '0;
            StWait: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (lsu_io.dmem_rvalid) begin
                    err_d   = lsu_io.dmem_err;
                    rdata_d = (!we_q && !lsu_io.dmem_err) ? load_data : '0;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        lsu_io.req_ready  = (state_q == StIdle);
        lsu_io.dmem_req   = (state_q == StIssue);
        lsu_io.rsp_valid  = (state_q == StResp);
        lsu_io.rsp_rdata  = (state_q == StResp) ? rdata_q : '0;
        lsu_io.rsp_err    = (state_q == StResp) ? err_q : 1'b0;
        lsu_io.dmem_we    = we_q;
        lsu_io.dmem_addr  = {addr_q[31:2], 2'b00};
        case (funct3_q[1:0])
            2'b00:   lsu_io.dmem_be = 4'b0001 << addr_q[1:0];
            2'b01:   lsu_io.dmem_be = 4'b0011 << {addr_q[1], 1'b0};
            default: lsu_io.dmem_be = 4'b1111;
        endcase
        // Stores replicate the narrow datum into every lane; the byte enables pick the one used.
        lsu_io.dmem_wdata = '0;
        if (we_q) begin
            case (funct3_q[1:0])
                2'b00:   lsu_io.dmem_wdata = {4{wdata_q[7:0]}};
                2'b01:   lsu_io.dmem_wdata = {2{wdata_q[15:0]}};
                default: lsu_io.dmem_wdata = wdata_q;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl_rv32i.sv
// Randomized self-checking bench for lsu_ctrl_rv32i against an arithmetic reference model.
module tb_lsu_ctrl_rv32i;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass = 0;

    lsu_ctrl_rv32i_if bus();

    lsu_ctrl_rv32i #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(16)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .lsu_io(bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    function automatic bit m_legal(bit we, int unsigned f3, int unsigned a);
        int unsigned sz = f3 % 4;
        if (we && f3 > 2) return 0;
        if (!we && (f3 == 3 || f3 == 6 || f3 == 7)) return 0;
        if (sz == 1 && a % 2 != 0) return 0;
        if (sz == 2 && a % 4 != 0) return 0;
        return 1;
    endfunction

    function automatic int unsigned m_be(int unsigned f3, int unsigned a);
        int unsigned sz = f3 % 4;
        if (sz == 0) return 1 << (a % 4);
        if (sz == 1) return (a % 4 >= 2) ? 12 : 3;
        return 15;
    endfunction

    function automatic int unsigned m_wdata(bit we, int unsigned f3, int unsigned wd);
        int unsigned sz = f3 % 4;
        if (!we) return 0;
        if (sz == 0) return (wd & 32'hff) * 32'h0101_0101;
        if (sz == 1) return (wd & 32'hffff) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic int unsigned m_rdata(int unsigned f3, int unsigned a, int unsigned rd);
        int unsigned sz = f3 % 4;
        int unsigned v;
        if (sz == 0) begin
            v = (rd >> (8 * (a % 4))) & 32'hff;
            if (f3 == 0 && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (sz == 1) begin
            v = (rd >> (16 * ((a % 4) / 2))) & 32'hffff;
            if (f3 == 1 && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return rd;
    endfunction

    // rd >= TO means memory never answers; gd is the number of ISSUE cycles before gnt.
    task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int gd, input int rd,
                           input logic [31:0] rdat, input bit rerr);
        bit          legal;
        bit          answered;
        logic [31:0] exp_data;
        logic        exp_err;
        check_eq("idle_ready", 32'(bus.req_ready), 32'd1);
        check_eq("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        legal    = m_legal(we, f3, addr);
        exp_err  = 1'b1;
        exp_data = '0;
        if (!legal) begin
            check_eq("illegal_no_req", 32'(bus.dmem_req), 32'd0);
        end else begin
            for (int i = 0; i <= gd; i++) begin
                check_eq("issue_req", 32'(bus.dmem_req), 32'd1);
                check_eq("issue_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                check_eq("issue_ready", 32'(bus.req_ready), 32'd0);
                check_eq("dmem_addr", bus.dmem_addr, addr & 32'hFFFF_FFFC);
                check_eq("dmem_we", 32'(bus.dmem_we), 32'(we));
                check_eq("dmem_be", 32'(bus.dmem_be), m_be(f3, addr));
                check_eq("dmem_wdata", bus.dmem_wdata, m_wdata(we, f3, wd));
                bus.dmem_gnt    = (i == gd);
                bus.dmem_rvalid = 1'($urandom);
                bus.dmem_rdata  = $urandom;
                bus.dmem_err    = 1'($urandom);
                @(posedge clk); #1;
            end
            bus.dmem_gnt    = 1'b0;
            bus.dmem_rvalid = 1'b0;
            answered        = 1'b0;
            for (int w = 0; w < int'(TO); w++) begin
                check_eq("wait_req", 32'(bus.dmem_req), 32'd0);
                check_eq("wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                if (w == rd) begin
                    bus.dmem_rvalid = 1'b1;
                    bus.dmem_rdata  = rdat;
                    bus.dmem_err    = rerr;
                end
                @(posedge clk); #1;
                bus.dmem_rvalid = 1'b0;
                if (w == rd) begin
                    answered = 1'b1;
                    break;
                end
            end
            if (answered) begin
                exp_err  = rerr;
                exp_data = (!we && !rerr) ? m_rdata(f3, addr, rdat) : 32'd0;
            end
        end
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check_eq("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        check_eq("rsp_rdata", bus.rsp_rdata, exp_data);
        check_eq("resp_ready", 32'(bus.req_ready), 32'd0);
        // A stray response in RESP must not disturb the result or the return to IDLE.
        bus.dmem_rvalid = 1'b1;
        bus.dmem_err    = 1'b1;
        bus.dmem_rdata  = $urandom;
        @(posedge clk); #1;
        bus.dmem_rvalid = 1'b0;
        check_eq("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("post_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_eq("post_rsp_rdata", bus.rsp_rdata, 32'd0);
    endtask

    task automatic reset_mid(input bit in_wait);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_6000;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        check_eq("rst_mid_issue", 32'(bus.dmem_req), 32'd1);
        if (in_wait) begin
            bus.dmem_gnt = 1'b1;
            @(posedge clk); #1;
            bus.dmem_gnt = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_req", 32'(bus.dmem_req), 32'd0);
        check_eq("rst_mid_rsp", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_eq("late_rv_idle_rsp", 32'(bus.rsp_valid), 32'd0);
            check_eq("late_rv_idle_ready", 32'(bus.req_ready), 32'd1);
        end
        bus.dmem_rvalid = 1'b0;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        bit          we;
        rst_n           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_we      = 1'b0;
        bus.req_funct3  = '0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = '0;
        bus.dmem_err    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234, 1'b0);
        run_txn(1'b0, 3'b100, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234, 1'b0);
        run_txn(1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 0, 0, 32'hFFFF_FFFF, 1'b0);
        run_txn(1'b0, 3'b010, 32'h0000_3001, 32'h0, 0, 0, 32'h0, 1'b0);
        run_txn(1'b0, 3'b011, 32'h0000_3000, 32'h0, 0, 0, 32'h0, 1'b0);
        run_txn(1'b0, 3'b101, 32'h0000_4002, 32'h0, 5, 2, 32'hABCD_0000, 1'b0);
        run_txn(1'b0, 3'b010, 32'h0000_5000, 32'h0, 1, int'(TO), 32'h0, 1'b0);
        run_txn(1'b0, 3'b010, 32'h0000_5004, 32'h0, 0, int'(TO) - 1, 32'hCAFE_F00D, 1'b1);
        reset_mid(1'b0);
        reset_mid(1'b1);

        for (int n = 0; n < 250; n++) begin
            we = 1'($urandom);
            f3 = 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (we) f3 = 3'($urandom_range(0, 2));
                else if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) f3 = 3'b010;
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            run_txn(we, f3, a, $urandom, $urandom_range(0, 4), $urandom_range(0, TO + 1),
                    $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
